// File: rtl/arc_run_halt_pkg.sv
// rtl/arc_run_halt_pkg.sv - shared types and encodings for the run/halt requester
package arc_run_halt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAKE = 3'd1,
    REQ  = 3'd2,
    REL  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [1:0] RSP_OK       = 2'd0;
  localparam logic [1:0] RSP_ACK_TO   = 2'd1;
  localparam logic [1:0] RSP_REL_TO   = 2'd2;
  localparam logic [1:0] RSP_MISMATCH = 2'd3;

  localparam logic OP_HALT = 1'b0;
  localparam logic OP_RUN  = 1'b1;

  // A completed handshake must leave the core in the state the op asked for.
  function automatic logic [1:0] done_code(input logic op, input logic halted);
    if (((op == OP_HALT) && !halted) || ((op == OP_RUN) && halted))
      return RSP_MISMATCH;
    return RSP_OK;
  endfunction

endpackage

// File: rtl/arc_run_halt_requester_if.sv
// rtl/arc_run_halt_requester_if.sv - command/response and core handshake bundle
// Optional macro ARC_RUN_HALT_WAKE_EN adds arc_wake_evt_a.
interface arc_run_halt_requester_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic       arc_halt_req_a;
  logic       arc_run_req_a;
  logic       arc_halt_ack;
  logic       arc_run_ack;
  logic       sys_halt_r;
  logic       sys_sleep_r;
`ifdef ARC_RUN_HALT_WAKE_EN
  logic       arc_wake_evt_a;
`endif

  modport slave (
    input  cmd_valid, cmd_op, arc_halt_ack, arc_run_ack, sys_halt_r, sys_sleep_r,
    output cmd_ready, rsp_valid, rsp_code, arc_halt_req_a, arc_run_req_a
`ifdef ARC_RUN_HALT_WAKE_EN
    , output arc_wake_evt_a
`endif
  );

  modport master (
    output cmd_valid, cmd_op, arc_halt_ack, arc_run_ack, sys_halt_r, sys_sleep_r,
    input  cmd_ready, rsp_valid, rsp_code, arc_halt_req_a, arc_run_req_a
`ifdef ARC_RUN_HALT_WAKE_EN
    , input arc_wake_evt_a
`endif
  );

endinterface

// File: rtl/arc_sync_bit.sv
// rtl/arc_sync_bit.sv - multi-flop single-bit synchroniser, sync active-low reset
module arc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/arc_run_halt_requester.sv
// rtl/arc_run_halt_requester.sv - 4-phase run/halt request initiator with timeout
// Optional macro ARC_RUN_HALT_WAKE_EN adds the WAKE state and arc_wake_evt_a.
module arc_run_halt_requester
  import arc_run_halt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  arc_run_halt_requester_if.slave bus
);

  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_op;
  logic             w_next_op;
  logic [1:0]       r_code;
  logic [1:0]       w_next_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_halt_req;
  logic             r_run_req;

  logic w_halt_ack_s;
  logic w_run_ack_s;
  logic w_halt_s;
  logic w_sleep_s;
  logic w_ack_s;
  logic w_expire;
  logic w_accept;
  logic w_cmd_ready;
  logic w_rsp_valid;
  logic [1:0] w_rsp_code;

  arc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_halt_ack (
    .clk(clk), .rst_n(rst_n), .i_d(bus.arc_halt_ack), .o_q(w_halt_ack_s));
  arc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run_ack (
    .clk(clk), .rst_n(rst_n), .i_d(bus.arc_run_ack), .o_q(w_run_ack_s));
  arc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_halt (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sys_halt_r), .o_q(w_halt_s));
  arc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sleep (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sys_sleep_r), .o_q(w_sleep_s));

  assign w_accept  = bus.cmd_valid && w_cmd_ready;
  assign w_next_op = w_accept ? bus.cmd_op : r_op;
  // Only the ack belonging to the latched op steers the handshake.
  assign w_ack_s   = (r_op == OP_RUN) ? w_run_ack_s : w_halt_ack_s;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_expire  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Timeout checks come first in every waiting state so they beat a coincident ack edge.
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_code;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_code  = RSP_OK;
          w_next_state = REQ;
`ifdef ARC_RUN_HALT_WAKE_EN
          if ((bus.cmd_op == OP_RUN) && w_sleep_s) w_next_state = WAKE;
`endif
        end
      end
`ifdef ARC_RUN_HALT_WAKE_EN
      WAKE: begin
        if (w_expire) begin
          w_next_state = RESP;
          w_next_code  = RSP_ACK_TO;
        end else if (!w_sleep_s) begin
          w_next_state = REQ;
        end
      end
`else
      WAKE: w_next_state = IDLE;
`endif
      REQ: begin
        if (w_expire) begin
          w_next_state = RESP;
          w_next_code  = RSP_ACK_TO;
        end else if (w_ack_s) begin
          w_next_state = REL;
        end
      end
      REL: begin
        if (w_expire) begin
          w_next_state = RESP;
          w_next_code  = RSP_REL_TO;
        end else if (!w_ack_s) begin
          w_next_state = RESP;
          w_next_code  = done_code(r_op, w_halt_s);
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = (r_state == IDLE) && !w_halt_ack_s && !w_run_ack_s;
    w_rsp_valid = (r_state == RESP);
    w_rsp_code  = w_rsp_valid ? r_code : RSP_OK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= OP_HALT;
      r_code     <= RSP_OK;
      r_halt_req <= 1'b0;
      r_run_req  <= 1'b0;
    end else begin
      r_op       <= w_next_op;
      r_code     <= w_next_code;
      r_halt_req <= (w_next_state == REQ) && (w_next_op == OP_HALT);
      r_run_req  <= (w_next_state == REQ) && (w_next_op == OP_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (((r_state == REQ) || (r_state == REL) || (r_state == WAKE)) && (r_cnt != CNT_MAX)) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.rsp_valid      = w_rsp_valid;
  assign bus.rsp_code       = w_rsp_code;
  assign bus.arc_halt_req_a = r_halt_req;
  assign bus.arc_run_req_a  = r_run_req;
`ifdef ARC_RUN_HALT_WAKE_EN
  assign bus.arc_wake_evt_a = (r_state == WAKE);
`else
  logic w_unused_sleep;
  assign w_unused_sleep = w_sleep_s;
`endif

  a_one_req: assert property (@(posedge clk) disable iff (!rst_n) !(r_halt_req && r_run_req));

endmodule

// File: tb/tb_arc_run_halt_requester.sv
// tb/tb_arc_run_halt_requester.sv - self-checking bench for arc_run_halt_requester
module tb_arc_run_halt_requester;

  localparam int TO = 16;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  arc_run_halt_requester_if bus();

  arc_run_halt_requester #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Issues one command at a negedge and plays the core side until the response.
  task automatic do_cmd(input bit op, input int dly, input int hold, input bit never,
                        input bit stuck, input bit noise, input int wake_at,
                        output int code, output int lat, output int reqc, output int nrsp,
                        output bit both, output int wakec, output bit req_in_wake);
    int hc;
    bit ack, got, sel;
    code = -1; lat = 0; reqc = 0; nrsp = 0; both = 0; wakec = 0; req_in_wake = 0;
    hc = 0; ack = 0; got = 0;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      if (bus.arc_halt_req_a && bus.arc_run_req_a) both = 1'b1;
`ifdef ARC_RUN_HALT_WAKE_EN
      if (bus.arc_wake_evt_a) begin
        wakec++;
        if (bus.arc_run_req_a || bus.arc_halt_req_a) req_in_wake = 1'b1;
      end
`endif
      if (bus.rsp_valid) begin
        nrsp++; code = int'(bus.rsp_code); lat = k; got = 1'b1;
      end
      sel = op ? bus.arc_run_req_a : bus.arc_halt_req_a;
      if (sel) begin
        reqc++;
        if (!never && (reqc - 1 >= dly)) ack = 1'b1;
      end else if (ack && !stuck) begin
        if (hc >= hold) ack = 1'b0;
        else hc++;
      end
      if (wake_at > 0 && k == wake_at) bus.sys_sleep_r = 1'b0;
      if (op) begin
        bus.arc_run_ack = ack; bus.arc_halt_ack = noise && sel;
      end else begin
        bus.arc_halt_ack = ack; bus.arc_run_ack = noise && sel;
      end
      if (!got) @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
  endtask

  task automatic settle_status(input bit halted, input bit sleeping);
    bus.sys_halt_r = halted;
    bus.sys_sleep_r = sleeping;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b expected 1", bus.cmd_ready); end
    n_tests++; if (bus.arc_halt_req_a !== 1'b0) begin n_fail++; $display("FAIL reset_halt_req: got %0b expected 0", bus.arc_halt_req_a); end
    n_tests++; if (bus.arc_run_req_a !== 1'b0) begin n_fail++; $display("FAIL reset_run_req: got %0b expected 0", bus.arc_run_req_a); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_code !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_code: got %0d expected 0", bus.rsp_code); end
`ifdef ARC_RUN_HALT_WAKE_EN
    n_tests++; if (bus.arc_wake_evt_a !== 1'b0) begin n_fail++; $display("FAIL reset_wake: got %0b expected 0", bus.arc_wake_evt_a); end
`endif
  endtask

  task automatic test_halt_ok();
    int code, lat, reqc, nrsp, wakec; bit both, riw;
    settle_status(1'b1, 1'b0);
    do_cmd(1'b0, 3, 5, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 0) begin n_fail++; $display("FAIL halt_ok_code: got %0d expected 0", code); end
    n_tests++; if (nrsp !== 1) begin n_fail++; $display("FAIL halt_ok_nrsp: got %0d expected 1", nrsp); end
    n_tests++; if (reqc !== 3 + S + 1) begin n_fail++; $display("FAIL halt_ok_req_cycles: got %0d expected %0d", reqc, 3 + S + 1); end
    n_tests++; if (lat !== 3 + 5 + 2*S + 3) begin n_fail++; $display("FAIL halt_ok_latency: got %0d expected %0d", lat, 3 + 5 + 2*S + 3); end
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ok_ready_after: got %0b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_min_latency();
    int code, lat, reqc, nrsp, wakec; bit both, riw;
    settle_status(1'b0, 1'b0);
    do_cmd(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (lat !== 2*S + 3) begin n_fail++; $display("FAIL min_latency: got %0d expected %0d", lat, 2*S + 3); end
    n_tests++; if (code !== 0) begin n_fail++; $display("FAIL min_latency_code: got %0d expected 0", code); end
  endtask

  task automatic test_ack_timeout();
    int code, lat, reqc, nrsp, wakec; bit both, riw;
    settle_status(1'b0, 1'b0);
    do_cmd(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 1) begin n_fail++; $display("FAIL ack_to_code: got %0d expected 1", code); end
    n_tests++; if (reqc !== TO) begin n_fail++; $display("FAIL ack_to_req_cycles: got %0d expected %0d", reqc, TO); end
    n_tests++; if (lat !== TO + 1) begin n_fail++; $display("FAIL ack_to_latency: got %0d expected %0d", lat, TO + 1); end
    n_tests++; if (bus.arc_run_req_a !== 1'b0) begin n_fail++; $display("FAIL ack_to_req_after: got %0b expected 0", bus.arc_run_req_a); end
    n_tests++; if (nrsp !== 1) begin n_fail++; $display("FAIL ack_to_nrsp: got %0d expected 1", nrsp); end
  endtask

  task automatic test_rel_timeout();
    int code, lat, reqc, nrsp, wakec; bit both, riw, ok, rdy_seen;
    settle_status(1'b1, 1'b0);
    do_cmd(1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 2) begin n_fail++; $display("FAIL rel_to_code: got %0d expected 2", code); end
    n_tests++; if (lat !== 1 + S + TO + 2) begin n_fail++; $display("FAIL rel_to_latency: got %0d expected %0d", lat, 1 + S + TO + 2); end
    n_tests++; if (nrsp !== 1) begin n_fail++; $display("FAIL rel_to_nrsp: got %0d expected 1", nrsp); end
    rdy_seen = 1'b0;
    repeat (6) begin
      if (bus.cmd_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL rel_to_ready_blocked: got %0b expected 0", rdy_seen); end
    bus.arc_halt_ack = 1'b0;
    wait_ready(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rel_to_ready_return: got %0b expected 1", ok); end
  endtask

  task automatic test_mismatch();
    int code, lat, reqc, nrsp, wakec; bit both, riw;
    settle_status(1'b0, 1'b0);
    do_cmd(1'b0, 2, 1, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 3) begin n_fail++; $display("FAIL mismatch_halt: got %0d expected 3", code); end
    settle_status(1'b1, 1'b0);
    do_cmd(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 3) begin n_fail++; $display("FAIL mismatch_run: got %0d expected 3", code); end
  endtask

  task automatic test_reset_mid();
    int code, lat, reqc, nrsp, wakec, stray; bit both, riw, ok;
    settle_status(1'b1, 1'b0);
    bus.cmd_op = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.arc_run_req_a !== 1'b1) begin n_fail++; $display("FAIL reset_mid_req_high: got %0b expected 1", bus.arc_run_req_a); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if ({bus.arc_run_req_a, bus.arc_halt_req_a, bus.rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b expected 000", {bus.arc_run_req_a, bus.arc_halt_req_a, bus.rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.arc_run_req_a || bus.arc_halt_req_a) stray++;
    end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL reset_mid_no_rsp: got %0d expected 0", stray); end
    wait_ready(ok);
    do_cmd(1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (code !== 0 || nrsp !== 1) begin n_fail++; $display("FAIL reset_mid_next_cmd: got code %0d nrsp %0d expected code 0 nrsp 1", code, nrsp); end
  endtask

  task automatic test_sleep();
    int code, lat, reqc, nrsp, wakec; bit both, riw, ok;
    settle_status(1'b0, 1'b1);
    wait_ready(ok);
`ifdef ARC_RUN_HALT_WAKE_EN
    do_cmd(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 5, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (wakec !== 5 + S) begin n_fail++; $display("FAIL wake_cycles: got %0d expected %0d", wakec, 5 + S); end
    n_tests++; if (riw !== 1'b0) begin n_fail++; $display("FAIL wake_req_overlap: got %0b expected 0", riw); end
    n_tests++; if (lat !== 5 + S + 1 + 2 + 2*S + 3) begin n_fail++; $display("FAIL wake_latency: got %0d expected %0d", lat, 5 + S + 1 + 2 + 2*S + 3); end
`else
    do_cmd(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 0, code, lat, reqc, nrsp, both, wakec, riw);
    n_tests++; if (lat !== 1 + 2 + 2*S + 3) begin n_fail++; $display("FAIL sleep_ignored_latency: got %0d expected %0d", lat, 1 + 2 + 2*S + 3); end
`endif
    n_tests++; if (code !== 0) begin n_fail++; $display("FAIL sleep_code: got %0d expected 0", code); end
    settle_status(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int code, lat, reqc, nrsp, wakec, dly, hold, exp_code; bit both, riw, ok, op, sh, noise;
    for (int i = 0; i < 24; i++) begin
      op    = 1'($urandom_range(0, 1));
      sh    = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      dly   = int'($urandom_range(0, 5));
      hold  = int'($urandom_range(0, 5));
      settle_status(sh, 1'b0);
      wait_ready(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0b expected 1", i, ok); end
      do_cmd(op, dly, hold, 1'b0, 1'b0, noise, 0, code, lat, reqc, nrsp, both, wakec, riw);
      exp_code = ((op == 1'b0 && !sh) || (op == 1'b1 && sh)) ? 3 : 0;
      n_tests++; if (code !== exp_code) begin n_fail++; $display("FAIL rand_code[%0d]: got %0d expected %0d", i, code, exp_code); end
      n_tests++; if (lat !== dly + hold + 2*S + 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, dly + hold + 2*S + 3); end
      n_tests++; if (reqc !== dly + S + 1) begin n_fail++; $display("FAIL rand_req_cycles[%0d]: got %0d expected %0d", i, reqc, dly + S + 1); end
      n_tests++; if (nrsp !== 1 || both !== 1'b0) begin n_fail++; $display("FAIL rand_rsp_once[%0d]: got nrsp %0d both %0b expected 1 0", i, nrsp, both); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0;
    bus.arc_halt_ack = 1'b0; bus.arc_run_ack = 1'b0;
    bus.sys_halt_r = 1'b0; bus.sys_sleep_r = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_halt_ok();
    test_min_latency();
    test_ack_timeout();
    test_rel_timeout();
    test_mismatch();
    test_reset_mid();
    test_sleep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
